// File: rtl/amo_pkg.sv
// Shared definitions for the atomic-memory-operation executor: funct5 codes,
// FSM state encoding and the read-modify-write classifier.
`ifndef CORE_NUMS
`define CORE_NUMS 4
`endif

package amo_pkg;

   localparam logic [4:0] F5_ADD  = 5'b00000;
   localparam logic [4:0] F5_SWAP = 5'b00001;
   localparam logic [4:0] F5_LR   = 5'b00010;
   localparam logic [4:0] F5_SC   = 5'b00011;
   localparam logic [4:0] F5_XOR  = 5'b00100;
   localparam logic [4:0] F5_OR   = 5'b01000;
   localparam logic [4:0] F5_AND  = 5'b01100;
   localparam logic [4:0] F5_MIN  = 5'b10000;
   localparam logic [4:0] F5_MAX  = 5'b10100;
   localparam logic [4:0] F5_MINU = 5'b11000;
   localparam logic [4:0] F5_MAXU = 5'b11100;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_t;

   function automatic logic is_rmw(input logic [4:0] f5);
      case (f5)
         F5_ADD, F5_SWAP, F5_XOR, F5_OR, F5_AND,
         F5_MIN, F5_MAX, F5_MINU, F5_MAXU: return 1'b1;
         default:                          return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/amo_executor_if.sv
// Arbiter-side request/response bus of the AMO executor.
interface amo_executor_if #(
   parameter int XLEN           = 32,
   parameter int CORE_NUMS_BITS = 2
) ();

   logic [CORE_NUMS_BITS-1:0] AMO_id_i;
   logic                      AMO_strobe_i;
   logic [XLEN-1:0]           AMO_addr_i;
   logic                      AMO_rw_i;
   logic [XLEN-1:0]           AMO_data_i;
   logic                      AMO_is_amo_i;
   logic [4:0]                AMO_amo_type_i;
   logic                      AMO_data_ready_o;
   logic [XLEN-1:0]           AMO_data_o;

   modport slave (
      input  AMO_id_i, AMO_strobe_i, AMO_addr_i, AMO_rw_i, AMO_data_i,
             AMO_is_amo_i, AMO_amo_type_i,
      output AMO_data_ready_o, AMO_data_o
   );

   modport master (
      output AMO_id_i, AMO_strobe_i, AMO_addr_i, AMO_rw_i, AMO_data_i,
             AMO_is_amo_i, AMO_amo_type_i,
      input  AMO_data_ready_o, AMO_data_o
   );

endinterface

// File: rtl/amo_alu.sv
// New memory value for a read-modify-write atomic, given the old word and operand.
module amo_alu
   import amo_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      amo_type,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] operand,
   output logic [XLEN-1:0] new_val
);

   always_comb begin
      new_val = old_val;
      case (amo_type)
         F5_SWAP: new_val = operand;
         F5_ADD:  new_val = old_val + operand;
         F5_XOR:  new_val = old_val ^ operand;
         F5_AND:  new_val = old_val & operand;
         F5_OR:   new_val = old_val | operand;
         F5_MIN:  new_val = ($signed(old_val) < $signed(operand)) ? old_val : operand;
         F5_MAX:  new_val = ($signed(old_val) > $signed(operand)) ? old_val : operand;
         F5_MINU: new_val = (old_val < operand) ? old_val : operand;
         F5_MAXU: new_val = (old_val > operand) ? old_val : operand;
         default: new_val = old_val;
      endcase
   end

endmodule

// File: rtl/amo_executor.sv
// Executes plain and atomic (LR/SC/AMO*) accesses against a single memory port,
// tracking one LR reservation per core.
//
// state   | meaning
// S_IDLE  | waiting for a request strobe; failed SC completes straight from here
// S_READ  | read issued, waiting for memory response
// S_WRITE | write issued (store, SC or RMW write-back), waiting for memory response
// S_DONE  | one-cycle completion pulse to the arbiter
module amo_executor
   import amo_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int CORE_NUMS      = `CORE_NUMS,
   parameter int CORE_NUMS_BITS = (CORE_NUMS == 1) ? 1 : $clog2(CORE_NUMS)
) (
   input  logic            clk_i,
   input  logic            rst_i,
   amo_executor_if.slave   amo,
   output logic            M_strobe_o,
   output logic [XLEN-1:0] M_addr_o,
   output logic            M_rw_o,
   output logic [XLEN-1:0] M_data_o,
   input  logic [XLEN-1:0] M_data_i,
   input  logic            M_data_ready_i,
   input  logic            snoop_we_i,
   input  logic [XLEN-1:0] snoop_addr_i
);

   state_t state_q, state_d;

   logic [CORE_NUMS_BITS-1:0] id_q, id_d;
   logic [XLEN-3:0]           word_q, word_d;
   logic [XLEN-1:0]           data_q, data_d;
   logic                      is_amo_q, is_amo_d;
   logic [4:0]                type_q, type_d;
   logic [XLEN-1:0]           result_q, result_d;

   logic            m_strobe_d, m_rw_d, ready_d;
   logic [XLEN-1:0] m_addr_d, m_data_d, rdata_d, alu_new;
   logic            lr_set, sc_clear, sc_hit, wr_clear;

   logic [CORE_NUMS-1:0] res_valid_q, res_set, res_clr;
   logic [XLEN-3:0]      res_word_q [CORE_NUMS];

   logic unused_snoop_lsbs;
   assign unused_snoop_lsbs = ^snoop_addr_i[1:0];

   amo_alu #(.XLEN(XLEN)) u_alu (
      .amo_type (type_q),
      .old_val  (M_data_i),
      .operand  (data_q),
      .new_val  (alu_new)
   );

   assign sc_hit   = res_valid_q[amo.AMO_id_i] &&
                     (res_word_q[amo.AMO_id_i] == amo.AMO_addr_i[XLEN-1:2]);
   assign wr_clear = M_strobe_o && M_rw_o;

   always_comb begin
      state_d    = state_q;
      id_d       = id_q;
      word_d     = word_q;
      data_d     = data_q;
      is_amo_d   = is_amo_q;
      type_d     = type_q;
      result_d   = result_q;
      m_strobe_d = 1'b0;
      m_addr_d   = M_addr_o;
      m_rw_d     = M_rw_o;
      m_data_d   = M_data_o;
      ready_d    = 1'b0;
      rdata_d    = '0;
      lr_set     = 1'b0;
      sc_clear   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (amo.AMO_strobe_i) begin
               id_d     = amo.AMO_id_i;
               word_d   = amo.AMO_addr_i[XLEN-1:2];
               data_d   = amo.AMO_data_i;
               is_amo_d = amo.AMO_is_amo_i;
               type_d   = amo.AMO_amo_type_i;
               m_addr_d = amo.AMO_addr_i;
               m_data_d = amo.AMO_data_i;
               result_d = '0;
               if (amo.AMO_is_amo_i && amo.AMO_amo_type_i == F5_SC) begin
                  sc_clear = 1'b1;
                  if (sc_hit) begin
                     state_d    = S_WRITE;
                     m_strobe_d = 1'b1;
                     m_rw_d     = 1'b1;
                  end else begin
                     state_d = S_DONE;
                     ready_d = 1'b1;
                     rdata_d = XLEN'(1);
                  end
               end else begin
                  state_d    = (!amo.AMO_is_amo_i && amo.AMO_rw_i) ? S_WRITE : S_READ;
                  m_strobe_d = 1'b1;
                  m_rw_d     = !amo.AMO_is_amo_i && amo.AMO_rw_i;
               end
            end
         end
         S_READ: begin
            if (M_data_ready_i) begin
               lr_set = is_amo_q && (type_q == F5_LR);
               if (is_amo_q && is_rmw(type_q)) begin
                  state_d    = S_WRITE;
                  m_strobe_d = 1'b1;
                  m_rw_d     = 1'b1;
                  m_data_d   = alu_new;
                  result_d   = M_data_i;
               end else begin
                  state_d = S_DONE;
                  ready_d = 1'b1;
                  rdata_d = M_data_i;
               end
            end
         end
         S_WRITE: begin
            if (M_data_ready_i) begin
               state_d = S_DONE;
               ready_d = 1'b1;
               rdata_d = result_q;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // A snoop hitting the word being reserved this cycle must still win.
   always_comb begin
      res_set = '0;
      res_clr = '0;
      for (int c = 0; c < CORE_NUMS; c++) begin
         res_set[c] = lr_set && (id_q == CORE_NUMS_BITS'(c));
         res_clr[c] = (sc_clear && (amo.AMO_id_i == CORE_NUMS_BITS'(c))) ||
                      (wr_clear && (res_word_q[c] == M_addr_o[XLEN-1:2])) ||
                      (snoop_we_i && ((res_set[c] ? word_q : res_word_q[c]) ==
                                      snoop_addr_i[XLEN-1:2]));
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q              <= S_IDLE;
         id_q                 <= '0;
         word_q               <= '0;
         data_q               <= '0;
         is_amo_q             <= 1'b0;
         type_q               <= '0;
         result_q             <= '0;
         M_strobe_o           <= 1'b0;
         M_addr_o             <= '0;
         M_rw_o               <= 1'b0;
         M_data_o             <= '0;
         amo.AMO_data_ready_o <= 1'b0;
         amo.AMO_data_o       <= '0;
      end else begin
         state_q              <= state_d;
         id_q                 <= id_d;
         word_q               <= word_d;
         data_q               <= data_d;
         is_amo_q             <= is_amo_d;
         type_q               <= type_d;
         result_q             <= result_d;
         M_strobe_o           <= m_strobe_d;
         M_addr_o             <= m_addr_d;
         M_rw_o               <= m_rw_d;
         M_data_o             <= m_data_d;
         amo.AMO_data_ready_o <= ready_d;
         amo.AMO_data_o       <= rdata_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         res_valid_q <= '0;
         for (int c = 0; c < CORE_NUMS; c++) res_word_q[c] <= '0;
      end else begin
         for (int c = 0; c < CORE_NUMS; c++) begin
            if (res_clr[c])      res_valid_q[c] <= 1'b0;
            else if (res_set[c]) res_valid_q[c] <= 1'b1;
            if (res_set[c])      res_word_q[c]  <= word_q;
         end
      end
   end

endmodule
